// File: rtl/lsu_mem_ctrl.sv
// Load/store sequencer between the MEM stage and a single-port data bus.
// Accepts one access at a time, holds the pipeline until the bus answers,
// then returns aligned/extended load data or a fault code with a done pulse.
module lsu_mem_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] rdata,
    output logic [1:0]  fault,
    output logic        mreq,
    output logic        write,
    output logic [1:0]  size,
    output logic [31:0] baddr,
    output logic [31:0] bwdata,
    input  logic        bready,
    input  logic [31:0] brdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    // With TIMEOUT_CYCLES == 0 this wraps, but the compare is gated off then.
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic [2:0]  f3_q;       // funct3 of the access in flight, selects extension
    logic [31:0] to_cnt;     // BUSY cycles seen without bready

    logic        memop;
    logic        load_ok;
    logic        store_ok;
    logic [1:0]  req_fault;
    logic [1:0]  req_size;
    logic [31:0] req_bwdata;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] load_val;
    logic        timeout_hit;

    // Request decode: fault priority, bus size and lane-replicated store data
    always_comb begin
        memop     = req_valid & (mem_read | mem_write);
        stall     = memop & (state != RESP);
        load_ok   = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        store_ok  = funct3 inside {3'b000, 3'b001, 3'b010};
        req_fault = 2'b00;
        if (mem_read & mem_write)
            req_fault = 2'b11;
        else if ((mem_read & ~load_ok) | (mem_write & ~store_ok))
            req_fault = 2'b11;
        else if (((funct3[1:0] == 2'b01) & addr[0]) |
                 ((funct3[1:0] == 2'b10) & (addr[1:0] != 2'b00)))
            req_fault = 2'b01;

        case (funct3[1:0])
            2'b00: begin
                req_size   = 2'b10;
                req_bwdata = {4{wdata[7:0]}};
            end
            2'b01: begin
                req_size   = 2'b01;
                req_bwdata = {2{wdata[15:0]}};
            end
            default: begin
                req_size   = 2'b00;
                req_bwdata = wdata;
            end
        endcase
    end

    // Load lane extraction from the latched address and funct3
    always_comb begin
        byte_lane = brdata[{baddr[1:0], 3'b000} +: 8];
        half_lane = brdata[{baddr[1], 4'b0000} +: 16];
        case (f3_q)
            3'b000:  load_val = {{24{byte_lane[7]}}, byte_lane};
            3'b100:  load_val = {24'd0, byte_lane};
            3'b001:  load_val = {{16{half_lane[15]}}, half_lane};
            3'b101:  load_val = {16'd0, half_lane};
            default: load_val = brdata;
        endcase
        timeout_hit = (TIMEOUT_CYCLES != 0) && (to_cnt == TO_LAST);
    end

    // Access sequencer: IDLE -> BUSY -> RESP -> IDLE, all outputs registered
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            mreq   <= 1'b0;
            write  <= 1'b0;
            done   <= 1'b0;
            size   <= 2'b00;
            baddr  <= 32'd0;
            bwdata <= 32'd0;
            rdata  <= 32'd0;
            fault  <= 2'b00;
            f3_q   <= 3'b000;
            to_cnt <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    done  <= 1'b0;
                    fault <= 2'b00;
                    if (memop) begin
                        if (req_fault != 2'b00) begin
                            // Faulted requests never reach the bus
                            state <= RESP;
                            done  <= 1'b1;
                            fault <= req_fault;
                        end else begin
                            state  <= BUSY;
                            mreq   <= 1'b1;
                            write  <= mem_write;
                            size   <= req_size;
                            baddr  <= addr;
                            bwdata <= req_bwdata;
                            f3_q   <= funct3;
                            to_cnt <= 32'd0;
                        end
                    end
                end
                BUSY: begin
                    if (bready) begin
                        // bready beats a coincident timeout
                        state <= RESP;
                        mreq  <= 1'b0;
                        write <= 1'b0;
                        done  <= 1'b1;
                        fault <= 2'b00;
                        if (!write)
                            rdata <= load_val;
                    end else if (timeout_hit) begin
                        state <= RESP;
                        mreq  <= 1'b0;
                        write <= 1'b0;
                        done  <= 1'b1;
                        fault <= 2'b10;
                    end else begin
                        to_cnt <= to_cnt + 32'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    fault <= 2'b00;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl. A transaction-level model predicts, per
// cycle, what stall/mreq/done/fault/rdata and the bus fields must be; one
// negedge process compares. Hand-computed literals pin the model results.
module tb_lsu_mem_ctrl;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, mem_read, mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;
    logic        stall, done, mreq, write;
    logic [31:0] rdata, baddr, bwdata;
    logic [1:0]  fault, size;
    logic        bready;
    logic [31:0] brdata;

    lsu_mem_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .mem_read(mem_read),
        .mem_write(mem_write), .funct3(funct3), .addr(addr), .wdata(wdata),
        .stall(stall), .done(done), .rdata(rdata), .fault(fault), .mreq(mreq),
        .write(write), .size(size), .baddr(baddr), .bwdata(bwdata),
        .bready(bready), .brdata(brdata)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Per-cycle expectations set by the driver, checked at negedge
    bit          chk_en  = 0;
    bit          chk_bus = 0;
    logic        exp_stall = 0, exp_mreq = 0, exp_done = 0, exp_write = 0;
    logic [1:0]  exp_fault = 0, exp_size = 0;
    logic [31:0] exp_rdata = 0, exp_baddr = 0, exp_bwdata = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---- model ----
    function automatic logic [1:0] m_fault(input logic rd, input logic wr,
                                           input logic [2:0] f3, input logic [31:0] a);
        if (rd && wr) return 2'b11;
        if (rd && !(f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5)) return 2'b11;
        if (wr && f3 > 2) return 2'b11;
        if (f3[1:0] == 2'd1 && a[0]) return 2'b01;
        if (f3[1:0] == 2'd2 && a[1:0] != 0) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] br);
        logic [31:0] v;
        v = br >> (8 * a[1:0]);
        case (f3)
            3'd0: return (v & 32'hFF) - ((v & 32'h80) << 1);
            3'd4: return v & 32'hFF;
            3'd1: return (v & 32'hFFFF) - ((v & 32'h8000) << 1);
            3'd5: return v & 32'hFFFF;
            default: return br;
        endcase
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
        if (f3[1:0] == 0) return (wd & 32'hFF) * 32'h0101_0101;
        if (f3[1:0] == 1) return (wd & 32'hFFFF) * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [1:0] m_size(input logic [2:0] f3);
        if (f3[1:0] == 0) return 2'b10;
        if (f3[1:0] == 1) return 2'b01;
        return 2'b00;
    endfunction

    // ---- single compare process ----
    always @(negedge clk) begin
        if (chk_en) begin
            check("stall", stall, exp_stall);
            check("mreq",  mreq,  exp_mreq);
            check("done",  done,  exp_done);
            check("fault", fault, exp_fault);
            check("rdata", rdata, exp_rdata);
            if (chk_bus) begin
                check("baddr",  baddr,  exp_baddr);
                check("size",   size,   exp_size);
                check("write",  write,  exp_write);
                if (exp_write) check("bwdata", bwdata, exp_bwdata);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_exp();
        exp_stall = 0; exp_mreq = 0; exp_done = 0; exp_fault = 0; chk_bus = 0;
    endtask

    // One access. dly = bready-low BUSY cycles before bready (>=TO means never).
    // lf/lr are hand-computed literal fault/rdata checked in the response cycle.
    task automatic run(input string name, input logic rd, input logic wr,
                       input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                       input int dly, input logic [31:0] br,
                       input logic [1:0] lf, input bit chk_r, input logic [31:0] lr);
        logic [1:0] f;
        bit hit, tmo;
        int busy_cycles;
        f = m_fault(rd, wr, f3, a);
        hit = 0; tmo = 0; busy_cycles = 0;
        req_valid = 1; mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
        idle_exp(); exp_stall = 1;
        step();
        if (f == 2'b00) begin
            exp_baddr = a; exp_size = m_size(f3); exp_write = wr; exp_bwdata = m_wdata(f3, wd);
            for (int j = 1; j <= 64; j++) begin
                bready = (j == dly + 1); brdata = br;
                exp_mreq = 1; exp_stall = 1; chk_bus = 1;
                hit = bready;
                tmo = !bready && (j == TO);
                busy_cycles++;
                step();
                if (hit || tmo) break;
            end
            bready = 0;
            if (hit && rd) exp_rdata = m_load(f3, a, br);
        end
        exp_mreq = 0; chk_bus = 0; exp_stall = 0; exp_done = 1;
        exp_fault = (f != 0) ? f : (tmo ? 2'b10 : 2'b00);
        check({name, ".fault"}, fault, lf);
        if (chk_r) check({name, ".rdata"}, rdata, lr);
        if (f == 2'b00 && hit) check({name, ".busy"}, busy_cycles, dly + 1);
        step();
        req_valid = 0; mem_read = 0; mem_write = 0;
        idle_exp();
        step();
    endtask

    initial begin
        reset = 1; req_valid = 0; mem_read = 0; mem_write = 0; funct3 = 0;
        addr = 0; wdata = 0; bready = 0; brdata = 0;
        step(); step();
        // reset state
        check("rst.mreq", mreq, 0);
        check("rst.done", done, 0);
        check("rst.write", write, 0);
        check("rst.size", size, 0);
        check("rst.baddr", baddr, 0);
        check("rst.bwdata", bwdata, 0);
        check("rst.rdata", rdata, 0);
        check("rst.fault", fault, 0);
        reset = 0;
        idle_exp(); exp_rdata = 0; chk_en = 1;
        step();

        // 1. lw, bready with first mreq
        run("lw",  1, 0, 3'b010, 32'h100, 0, 0, 32'hDEADBEEF, 2'b00, 1, 32'hDEADBEEF);
        // 2. sub-word loads
        run("lb",  1, 0, 3'b000, 32'h103, 0, 0, 32'h80FF_FFFF, 2'b00, 1, 32'hFFFFFF80);
        run("lbu", 1, 0, 3'b100, 32'h103, 0, 0, 32'h80FF_FFFF, 2'b00, 1, 32'h00000080);
        run("lhu", 1, 0, 3'b101, 32'h102, 0, 0, 32'hBEEF_0000, 2'b00, 1, 32'h0000BEEF);
        run("lh",  1, 0, 3'b001, 32'h102, 0, 1, 32'hBEEF_0000, 2'b00, 1, 32'hFFFFBEEF);
        // 3. sb with bready low 3 cycles; rdata unchanged
        run("sb",  0, 1, 3'b000, 32'h201, 32'h12345678, 3, 32'h0, 2'b00, 1, 32'hFFFFBEEF);
        check("sb.bwdata", bwdata, 32'h78787878);
        check("sb.baddr",  baddr,  32'h201);
        check("sb.size",   size,   2'b10);
        run("sh",  0, 1, 3'b001, 32'h302, 32'hCAFE_1234, 0, 32'h0, 2'b00, 1, 32'hFFFFBEEF);
        check("sh.bwdata", bwdata, 32'h12341234);
        // 4. fault paths
        run("lw_mis", 1, 0, 3'b010, 32'h102, 0, 0, 0, 2'b01, 1, 32'hFFFFBEEF);
        run("sh_mis", 0, 1, 3'b001, 32'h301, 0, 0, 0, 2'b01, 0, 0);
        run("s_ill",  0, 1, 3'b100, 32'h300, 0, 0, 0, 2'b11, 0, 0);
        run("rw_ill", 1, 1, 3'b010, 32'h300, 0, 0, 0, 2'b11, 0, 0);
        run("l_ill",  1, 0, 3'b011, 32'h300, 0, 0, 0, 2'b11, 0, 0);
        // 5. timeout, then bready on the last allowed cycle
        run("tmo",    1, 0, 3'b010, 32'h500, 0, 100, 32'h5555_5555, 2'b10, 1, 32'hFFFFBEEF);
        run("tmo_rd", 1, 0, 3'b010, 32'h500, 0, 3,   32'h1357_9BDF, 2'b00, 1, 32'h13579BDF);

        // 6. reset mid-access
        req_valid = 1; mem_read = 1; mem_write = 0; funct3 = 3'b010; addr = 32'h400;
        idle_exp(); exp_stall = 1;
        step();
        exp_baddr = 32'h400; exp_size = 2'b00; exp_write = 0;
        for (int j = 0; j < 2; j++) begin
            exp_mreq = 1; exp_stall = 1; chk_bus = 1;
            step();
        end
        reset = 1; req_valid = 0; mem_read = 0;
        exp_stall = 0;
        step();
        reset = 0;
        idle_exp(); exp_rdata = 0;
        check("rst_mid.mreq", mreq, 0);
        check("rst_mid.done", done, 0);
        step(); step();
        run("lw_after", 1, 0, 3'b010, 32'h404, 0, 0, 32'hA5A5_0F0F, 2'b00, 1, 32'hA5A50F0F);

        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
